// File: rtl/alu_exec_stage.sv
// Two-stage execute pipeline around a 64-bit ALU: S1 registers decoded operands,
// S2 registers the ALU result. Both stages hand off over valid/ready.
module alu_exec_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_alu_op,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_5,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_res,
  output logic             out_zero,
  output logic [3:0]       out_ctrl,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [3:0] {
    CTRL_AND = 4'b0000,
    CTRL_OR  = 4'b0001,
    CTRL_ADD = 4'b0010,
    CTRL_SUB = 4'b0110
  } alu_ctrl_e;

  // Decode of ALUOp / funct3 / funct7[5] into the ALU control code
  alu_ctrl_e dec_ctrl;
  logic      dec_err;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec_ctrl = CTRL_AND;
    dec_err  = 1'b0;
    unique case (in_alu_op)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      2'b10: begin
        unique case (in_funct3)
          3'b000:  dec_ctrl = in_funct7_5 ? CTRL_SUB : CTRL_ADD;
          3'b111:  dec_ctrl = CTRL_AND;
          3'b110:  dec_ctrl = CTRL_OR;
          default: dec_err  = 1'b1;
        endcase
      end
      default: dec_err = 1'b1;
    endcase
  end

  logic             s1_valid_q;
  logic [63:0]      s1_a_q;
  logic [63:0]      s1_b_q;
  alu_ctrl_e        s1_ctrl_q;
  logic             s1_err_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q;
  logic [63:0]      s2_res_q;
  logic             s2_zero_q;
  logic [3:0]       s2_ctrl_q;
  logic             s2_err_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic s2_rdy;
  logic s1_rdy;

  assign s2_rdy   = !s2_valid_q || out_ready;
  assign s1_rdy   = !s1_valid_q || s2_rdy;
  // rst_n gating keeps upstream from seeing ready while the pipe is held in reset
  assign in_ready = s1_rdy && !flush && rst_n;

  logic [63:0] alu_res;

  always_comb begin
    alu_res = '0;
    unique case (s1_ctrl_q)
      CTRL_AND: alu_res = s1_a_q & s1_b_q;
      CTRL_OR:  alu_res = s1_a_q | s1_b_q;
      CTRL_ADD: alu_res = s1_a_q + s1_b_q;
      CTRL_SUB: alu_res = s1_a_q - s1_b_q;
      default:  alu_res = '0;
    endcase
  end

  logic [63:0] s2_res_d;
  logic        s2_zero_d;

  assign s2_res_d  = s1_err_q ? 64'd0 : alu_res;
  assign s2_zero_d = !s1_err_q && (alu_res == 64'd0);

  // NOTE: datapath regs are reset too so out_* read zero during reset; sequential state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ctrl_q  <= CTRL_AND;
      s1_err_q   <= 1'b0;
      s1_tag_q   <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (s1_rdy) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q    <= in_a;
        s1_b_q    <= in_b;
        s1_ctrl_q <= dec_ctrl;
        s1_err_q  <= dec_err;
        s1_tag_q  <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_ctrl_q  <= '0;
      s2_err_q   <= 1'b0;
      s2_tag_q   <= '0;
    end else if (flush) begin
      s2_valid_q <= 1'b0;
    end else if (s2_rdy) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_res_q  <= s2_res_d;
        s2_zero_q <= s2_zero_d;
        s2_ctrl_q <= s1_ctrl_q;
        s2_err_q  <= s1_err_q;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_res   = s2_res_q;
  assign out_zero  = s2_zero_q;
  assign out_ctrl  = s2_ctrl_q;
  assign out_err   = s2_err_q;
  assign out_tag   = s2_tag_q;

endmodule
